// File: rtl/arm_eim_sync.sv
// rtl/arm_eim_sync.sv - ARM926 CS5 bus front end: strobe sync, glitch reject, one strobe per access
module arm_eim_sync #(
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE      = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] ARM_A,
  input  logic [DATA_W-1:0] ARM_D_IN,
  input  logic [3:0]        ARM_BE_B,
  input  logic              CPLD_RS_B,
  input  logic              CPLD_WS_B,
  output logic [DATA_W-1:0] ARM_D_OUT,
  output logic              ARM_D_OE,
  output logic [ADDR_W-1:0] c_address,
  output logic [DATA_W-1:0] c_wdata,
  output logic [3:0]        c_be,
  output logic              c_wr,
  output logic              c_rd,
  input  logic [DATA_W-1:0] rd_data,
  output logic              bus_err
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_ISSUE,
    ST_RD_CAP,
    ST_WAIT_REL
  } state_t;

  logic [SYNC_STAGES-1:0] rs_sync;
  logic [SYNC_STAGES-1:0] ws_sync;
  logic                   rs_s;
  logic                   ws_s;
  logic                   settle_abort;
  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic                   dir_wr;

  // Chains reset to 0 (asserted) so an access caught by reset must be released first.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rs_sync <= '0;
      ws_sync <= '0;
    end else begin
      rs_sync <= {rs_sync[SYNC_STAGES-2:0], CPLD_RS_B};
      ws_sync <= {ws_sync[SYNC_STAGES-2:0], CPLD_WS_B};
    end
  end

  assign rs_s = rs_sync[SYNC_STAGES-1];
  assign ws_s = ws_sync[SYNC_STAGES-1];

  assign settle_abort = dir_wr ? (ws_s || !rs_s) : (rs_s || !ws_s);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_WAIT_REL;
      cnt       <= '0;
      dir_wr    <= 1'b0;
      ARM_D_OUT <= '0;
      ARM_D_OE  <= 1'b0;
      c_address <= '0;
      c_wdata   <= '0;
      c_be      <= '0;
      c_wr      <= 1'b0;
      c_rd      <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      c_wr    <= 1'b0;
      c_rd    <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!rs_s && !ws_s) begin
            bus_err <= 1'b1;
            state   <= ST_WAIT_REL;
          end else if (!ws_s) begin
            dir_wr <= 1'b1;
            cnt    <= '0;
            state  <= ST_SETTLE;
          end else if (!rs_s) begin
            dir_wr <= 1'b0;
            cnt    <= '0;
            state  <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_abort) begin
            state <= ST_IDLE;
          end else if (cnt == CNT_LAST) begin
            // Strobe is raised on the capture edge so it is high for the ISSUE cycle.
            c_address <= ARM_A;
            c_be      <= ~ARM_BE_B;
            if (dir_wr) begin
              c_wdata <= ARM_D_IN;
            end
            c_wr  <= dir_wr;
            c_rd  <= !dir_wr;
            state <= ST_ISSUE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_ISSUE: begin
          state <= dir_wr ? ST_WAIT_REL : ST_RD_CAP;
        end
        ST_RD_CAP: begin
          ARM_D_OUT <= rd_data;
          ARM_D_OE  <= 1'b1;
          state     <= ST_WAIT_REL;
        end
        ST_WAIT_REL: begin
          if (rs_s && ws_s) begin
            ARM_D_OE <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_WAIT_REL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arm_eim_sync.sv
// tb/tb_arm_eim_sync.sv - directed and randomized access checks against a timing-rule model
module tb_arm_eim_sync;

  localparam int AW = 24;
  localparam int DW = 32;
  localparam int SS = 2;
  localparam int ST = 2;
  localparam int E  = SS + ST + 1;

  localparam int K_WR = 0;
  localparam int K_RD = 1;
  localparam int K_CF = 2;

  logic          CLK;
  logic          RST;
  logic [AW-1:0] ARM_A;
  logic [DW-1:0] ARM_D_IN;
  logic [3:0]    ARM_BE_B;
  logic          CPLD_RS_B;
  logic          CPLD_WS_B;
  logic [DW-1:0] ARM_D_OUT;
  logic          ARM_D_OE;
  logic [AW-1:0] c_address;
  logic [DW-1:0] c_wdata;
  logic [3:0]    c_be;
  logic          c_wr;
  logic          c_rd;
  logic [DW-1:0] rd_data;
  logic          bus_err;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_dout;
  logic [3:0]    m_be;

  arm_eim_sync #(
    .ADDR_W(AW), .DATA_W(DW), .SYNC_STAGES(SS), .SETTLE(ST)
  ) dut (
    .CLK(CLK), .RST(RST), .ARM_A(ARM_A), .ARM_D_IN(ARM_D_IN), .ARM_BE_B(ARM_BE_B),
    .CPLD_RS_B(CPLD_RS_B), .CPLD_WS_B(CPLD_WS_B), .ARM_D_OUT(ARM_D_OUT),
    .ARM_D_OE(ARM_D_OE), .c_address(c_address), .c_wdata(c_wdata), .c_be(c_be),
    .c_wr(c_wr), .c_rd(c_rd), .rd_data(rd_data), .bus_err(bus_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int cyc, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_captured(input int cyc);
    chk("c_address", cyc, c_address, m_addr);
    chk("c_be", cyc, c_be, m_be);
    chk("c_wdata", cyc, c_wdata, m_wdata);
    chk("arm_d_out", cyc, ARM_D_OUT, m_dout);
  endtask

  // Strobe(s) held low for L sampling edges, then G released edges; k counts edges from the first low sample.
  task automatic run_access(input int kind, input int L, input int G, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input logic [3:0] be_b, input logic [DW-1:0] rdval);
    bit issue;
    int rel;
    int tot;
    issue = (kind != K_CF) && (L >= ST + 1);
    rel   = L + SS + 1;
    if (kind == K_RD && rel < E + 3) rel = E + 3;
    if (kind == K_WR && rel < E + 2) rel = E + 2;
    tot = L + G;
    ARM_A    = addr;
    ARM_D_IN = data;
    ARM_BE_B = be_b;
    rd_data  = $urandom;
    if (kind != K_RD) CPLD_WS_B = 1'b0;
    if (kind != K_WR) CPLD_RS_B = 1'b0;
    for (int k = 1; k <= tot; k++) begin
      @(negedge CLK);
      chk("c_wr", k, c_wr, issue && kind == K_WR && k == E);
      chk("c_rd", k, c_rd, issue && kind == K_RD && k == E);
      chk("bus_err", k, bus_err, kind == K_CF && k == SS + 1);
      chk("arm_d_oe", k, ARM_D_OE, issue && kind == K_RD && k >= E + 2 && k < rel);
      if (k == L) begin
        CPLD_RS_B = 1'b1;
        CPLD_WS_B = 1'b1;
      end
      if (k == E + 1) begin
        rd_data  = rdval;
        ARM_A    = AW'($urandom);
        ARM_D_IN = $urandom;
        ARM_BE_B = 4'($urandom);
      end
      if (k == E + 2) rd_data = $urandom;
    end
    if (issue) begin
      m_addr = addr;
      m_be   = ~be_b;
      if (kind == K_WR) m_wdata = data;
      else m_dout = rdval;
    end
    chk_captured(tot);
  endtask

  initial begin
    int kind;
    int len;
    RST = 1'b1;
    CPLD_RS_B = 1'b1;
    CPLD_WS_B = 1'b1;
    ARM_A = '0;
    ARM_D_IN = '0;
    ARM_BE_B = '0;
    rd_data = '0;
    m_addr = '0;
    m_wdata = '0;
    m_dout = '0;
    m_be = '0;
    repeat (3) @(negedge CLK);
    chk("rst_c_wr", 0, c_wr, 0);
    chk("rst_c_rd", 0, c_rd, 0);
    chk("rst_bus_err", 0, bus_err, 0);
    chk("rst_oe", 0, ARM_D_OE, 0);
    chk_captured(0);
    RST = 1'b0;
    repeat (5) @(negedge CLK);

    run_access(K_WR, 10, 4, 24'h000010, 32'h12345678, 4'h0, 32'h0);
    run_access(K_RD, 12, 4, 24'h000020, 32'hDEADBEEF, 4'h0, 32'hCAFEF00D);
    run_access(K_WR, 1, 4, 24'h000030, 32'h55555555, 4'h0, 32'h0);
    run_access(K_WR, ST, 4, 24'h000034, 32'h66666666, 4'h0, 32'h0);
    run_access(K_CF, 8, 4, 24'h000038, 32'h77777777, 4'h0, 32'h0);
    run_access(K_WR, 10, 3, 24'h000040, 32'hA5A5A5A5, 4'hC, 32'h0);
    run_access(K_RD, 10, 4, 24'h000044, 32'h0, 4'h0, 32'h0BADF00D);

    // Reset while a read is being driven out and RS_B is still low.
    ARM_A = 24'h000050;
    ARM_BE_B = 4'h0;
    CPLD_RS_B = 1'b0;
    rd_data = 32'h11111111;
    for (int k = 1; k <= E + 2; k++) begin
      @(negedge CLK);
      if (k == E + 1) rd_data = 32'h24681357;
    end
    chk("mid_oe", E + 2, ARM_D_OE, 1);
    chk("mid_dout", E + 2, ARM_D_OUT, 32'h24681357);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    m_addr = '0;
    m_wdata = '0;
    m_dout = '0;
    m_be = '0;
    chk("rst_mid_oe", 0, ARM_D_OE, 0);
    chk_captured(0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      chk("held_c_rd", k, c_rd, 0);
      chk("held_oe", k, ARM_D_OE, 0);
      if (k == 6) CPLD_RS_B = 1'b1;
    end
    run_access(K_RD, 9, 4, 24'h000060, 32'h0, 4'h5, 32'h13572468);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      if (kind == K_CF) len = $urandom_range(1, 10);
      else if ($urandom_range(0, 3) == 0) len = $urandom_range(1, ST);
      else len = $urandom_range(ST + 1, 14);
      run_access(kind, len, $urandom_range(4, 7), AW'($urandom), $urandom, 4'($urandom), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
